// File: rtl/data_ram_responder.sv
// Data-memory responder for the MEM stage: single-outstanding load/store target with
// programmable fixed latency, RV32I byte/half/word lanes and error flagging.
module data_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [2:0]        reqFunc3,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqWData,
    output logic              respValid,
    output logic [31:0]       respData,
    output logic              respError
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lat_write_q;
    logic [2:0]         lat_func3_q;
    logic [ADDR_W-1:0]  lat_addr_q;
    logic [31:0]        lat_wdata_q;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               resp_error_q, resp_error_d;
    logic               req_ready_q, req_ready_d;
    logic               latch_en;
    logic               commit;

    // Storage is deliberately not reset; it may be preloaded externally.
    logic [31:0]        mem [DEPTH_WORDS];

    logic [WIDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic               in_range;
    logic [31:0]        rd_word;

    assign word_idx = lat_addr_q[ADDR_W-1:2];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = 32'(word_idx) < DEPTH_WORDS;
    assign rd_word  = mem[mem_idx];

    // funct3 decode into access size and signedness; unsigned forms exist only for loads
    logic size_byte, size_half, size_word, load_unsigned, f3_ok;

    always_comb begin
        size_byte     = 1'b0;
        size_half     = 1'b0;
        size_word     = 1'b0;
        load_unsigned = 1'b0;
        f3_ok         = 1'b0;
        case (lat_func3_q)
            3'b000: begin size_byte = 1'b1; f3_ok = 1'b1; end
            3'b001: begin size_half = 1'b1; f3_ok = 1'b1; end
            3'b010: begin size_word = 1'b1; f3_ok = 1'b1; end
            3'b100: begin size_byte = 1'b1; load_unsigned = 1'b1; f3_ok = ~lat_write_q; end
            3'b101: begin size_half = 1'b1; load_unsigned = 1'b1; f3_ok = ~lat_write_q; end
            default: ;
        endcase
    end

    logic misaligned;
    logic acc_error;

    assign misaligned = (size_half & lat_addr_q[0]) |
                        (size_word & (lat_addr_q[1:0] != 2'b00));
    assign acc_error  = ~f3_ok | misaligned | ~in_range;

    // Load lane extraction and extension
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    always_comb begin
        ld_byte = rd_word[7:0];
        case (lat_addr_q[1:0])
            2'd0: ld_byte = rd_word[7:0];
            2'd1: ld_byte = rd_word[15:8];
            2'd2: ld_byte = rd_word[23:16];
            2'd3: ld_byte = rd_word[31:24];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = lat_addr_q[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = rd_word;
        if (size_byte) begin
            load_data = load_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (size_half) begin
            load_data = load_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

    // Store lane merge: replicate right-aligned data across lanes, then byte-enable select
    logic [3:0]  st_be;
    logic [31:0] st_lanes;
    logic [31:0] st_word;

    always_comb begin
        st_be    = 4'b1111;
        st_lanes = lat_wdata_q;
        if (size_byte) begin
            st_be    = 4'b0001 << lat_addr_q[1:0];
            st_lanes = {4{lat_wdata_q[7:0]}};
        end else if (size_half) begin
            st_be    = lat_addr_q[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{lat_wdata_q[15:0]}};
        end
        for (int i = 0; i < 4; i++) begin
            st_word[8*i +: 8] = st_be[i] ? st_lanes[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        req_ready_d  = 1'b0;
        latch_en     = 1'b0;
        commit       = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (reqValid && req_ready_q) begin
                    latch_en    = 1'b1;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = S_BUSY;
                    req_ready_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = acc_error;
                    resp_data_d  = (acc_error || lat_write_q) ? 32'd0 : load_data;
                    commit       = lat_write_q & ~acc_error;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetIn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lat_write_q  <= 1'b0;
            lat_func3_q  <= '0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            req_ready_q  <= req_ready_d;
            if (latch_en) begin
                lat_write_q <= reqWrite;
                lat_func3_q <= reqFunc3;
                lat_addr_q  <= reqAddr;
                lat_wdata_q <= reqWData;
            end
        end
    end

    // Reset aborts a pending store even on its commit edge
    always_ff @(posedge clk) begin
        if (commit && !resetIn) begin
            mem[mem_idx] <= st_word;
        end
    end

    assign reqReady  = req_ready_q;
    assign respValid = resp_valid_q;
    assign respData  = resp_data_q;
    assign respError = resp_error_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: directed cases plus randomized traffic against a
// byte-array reference model.
module tb_data_ram_responder;

    localparam int unsigned LAT    = 2;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              resetIn;
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [2:0]        reqFunc3;
    logic [ADDR_W-1:0] reqAddr;
    logic [31:0]       reqWData;
    logic              respValid;
    logic [31:0]       respData;
    logic              respError;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_b [DEPTH*4];

    always #5 clk = ~clk;

    data_ram_responder #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (ADDR_W),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .resetIn  (resetIn),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqWrite (reqWrite),
        .reqFunc3 (reqFunc3),
        .reqAddr  (reqAddr),
        .reqWData (reqWData),
        .respValid(respValid),
        .respData (respData),
        .respError(respError)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory as bytes, access rules from the RV32I funct3 table
    task automatic model(input logic w, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd, output logic [31:0] d, output logic e);
        int nbytes;
        int ai;
        bit ok;
        bit uns;
        ok  = 1'b1;
        uns = 1'b0;
        ai  = int'(a);
        case (f3)
            3'd0: nbytes = 1;
            3'd1: nbytes = 2;
            3'd2: nbytes = 4;
            3'd4: begin nbytes = 1; uns = 1'b1; ok = !w; end
            3'd5: begin nbytes = 2; uns = 1'b1; ok = !w; end
            default: begin nbytes = 1; ok = 1'b0; end
        endcase
        e = !ok || (ai % nbytes != 0) || (ai / 4 >= int'(DEPTH));
        d = 32'd0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < nbytes; i++) mem_b[ai + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nbytes; i++) d[8*i +: 8] = mem_b[ai + i];
                if (!uns && nbytes < 4 && d[8*nbytes-1]) d = d | (32'hFFFF_FFFF << (8*nbytes));
            end
        end
    endtask

    task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                       input logic [9:0] a, input logic [31:0] wd, output logic [31:0] obs);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        model(w, f3, a, wd, exp_d, exp_e);
        n = 0;
        while (reqReady !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_ready"}, 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqWrite = w; reqFunc3 = f3; reqAddr = a; reqWData = wd;
        @(posedge clk); #1;
        chk({tag, "_accepted"}, 32'(reqReady), 32'd0);
        // Garbage on the request bus while busy must be ignored
        reqValid = 1'($urandom); reqWrite = 1'($urandom); reqFunc3 = 3'($urandom);
        reqAddr = 10'($urandom); reqWData = $urandom;
        n = 0;
        while (respValid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        reqValid = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
        obs = respData;
        chk({tag, "_data"}, respData, exp_d);
        chk({tag, "_err"}, 32'(respError), 32'(exp_e));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(respValid), 32'd0);
        chk({tag, "_ready_back"}, 32'(reqReady), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic        w;
        logic [2:0]  f3;
        logic [9:0]  a;

        // Reset with a request already held on the bus
        resetIn = 1'b1; reqValid = 1'b1; reqWrite = 1'b0; reqFunc3 = 3'd2;
        reqAddr = 10'h000; reqWData = 32'd0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(reqReady), 32'd0);
        chk("rst_valid", 32'(respValid), 32'd0);
        chk("rst_data", respData, 32'd0);
        chk("rst_err", 32'(respError), 32'd0);
        @(posedge clk); #1;
        chk("rst2_ready", 32'(reqReady), 32'd0);
        resetIn = 1'b0;
        @(posedge clk); #1;
        chk("rel_ready", 32'(reqReady), 32'd1);
        chk("rel_valid", 32'(respValid), 32'd0);
        @(posedge clk); #1;
        chk("first_accept", 32'(reqReady), 32'd0);
        reqValid = 1'b0;
        @(posedge clk); #1;
        chk("first_lat1", 32'(respValid), 32'd0);
        @(posedge clk); #1;
        chk("first_lat2", 32'(respValid), 32'd1);
        chk("first_err", 32'(respError), 32'd0);
        @(posedge clk); #1;
        chk("first_pulse", 32'(respValid), 32'd0);
        chk("first_ready", 32'(reqReady), 32'd1);

        // Directed load/store lanes (back-to-back: each starts in the ready cycle after RESP)
        txn("sw8", 1'b1, 3'd2, 10'h008, 32'h8081_F00D, d);
        chk("sw8_zero", d, 32'd0);
        txn("lw8", 1'b0, 3'd2, 10'h008, 32'd0, d);
        chk("lw8_const", d, 32'h8081_F00D);
        txn("lb_b", 1'b0, 3'd0, 10'h00B, 32'd0, d);
        chk("lb_b_const", d, 32'hFFFF_FF80);
        txn("lbu_b", 1'b0, 3'd4, 10'h00B, 32'd0, d);
        chk("lbu_b_const", d, 32'h0000_0080);
        txn("lh_a", 1'b0, 3'd1, 10'h00A, 32'd0, d);
        chk("lh_a_const", d, 32'hFFFF_8081);
        txn("lhu_8", 1'b0, 3'd5, 10'h008, 32'd0, d);
        chk("lhu_8_const", d, 32'h0000_F00D);
        txn("sb9", 1'b1, 3'd0, 10'h009, 32'h0000_00AA, d);
        txn("lw8_sb", 1'b0, 3'd2, 10'h008, 32'd0, d);
        chk("lw8_sb_const", d, 32'h8081_AA0D);

        // Error cases leave memory untouched
        txn("sw4", 1'b1, 3'd2, 10'h004, 32'hCAFE_BABE, d);
        txn("e_lw_mis", 1'b0, 3'd2, 10'h00A, 32'd0, d);
        txn("e_sh_mis", 1'b1, 3'd1, 10'h005, 32'hFFFF_FFFF, d);
        txn("lw4_chk", 1'b0, 3'd2, 10'h004, 32'd0, d);
        chk("lw4_const", d, 32'hCAFE_BABE);
        txn("e_f3_ld", 1'b0, 3'd3, 10'h008, 32'd0, d);
        txn("e_f3_st", 1'b1, 3'd4, 10'h008, 32'h1111_1111, d);
        txn("e_oor", 1'b0, 3'd2, 10'h100, 32'd0, d);
        txn("e_oor_st", 1'b1, 3'd2, 10'h100, 32'h2222_2222, d);
        txn("lw8_err", 1'b0, 3'd2, 10'h008, 32'd0, d);
        chk("lw8_err_const", d, 32'h8081_AA0D);

        // Reset on the commit edge of a store aborts it
        txn("sw10", 1'b1, 3'd2, 10'h010, 32'h1111_1111, d);
        reqValid = 1'b1; reqWrite = 1'b1; reqFunc3 = 3'd2; reqAddr = 10'h010;
        reqWData = 32'h1234_5678;
        @(posedge clk); #1;
        chk("abort_accept", 32'(reqReady), 32'd0);
        reqValid = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(respValid), 32'd0);
        resetIn = 1'b1;
        @(posedge clk); #1;
        chk("abort_rst_valid", 32'(respValid), 32'd0);
        chk("abort_rst_ready", 32'(reqReady), 32'd0);
        resetIn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 32'(respValid), 32'd0);
        end
        txn("lw10", 1'b0, 3'd2, 10'h010, 32'd0, d);
        chk("lw10_const", d, 32'h1111_1111);

        // Randomized traffic over a fully initialised low region
        for (int i = 0; i < 16; i++) begin
            txn("init", 1'b1, 3'd2, 10'(4*i), $urandom, d);
        end
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom);
            a  = ($urandom % 6 == 0) ? 10'(256 + $urandom % 768) : 10'($urandom % 64);
            txn("rnd", w, f3, a, $urandom, d);
        end
        for (int i = 0; i < 16; i++) begin
            txn("final", 1'b0, 3'd2, 10'(4*i), 32'd0, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
